// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4)+pad codeword layout, syndrome type and syndrome-to-position map
package hamming_pkg;
  typedef logic [2:0] syn_t;
  localparam int D0 = 0;
  localparam int D1 = 1;
  localparam int D2 = 2;
  localparam int D3 = 3;
  localparam int P0 = 4;
  localparam int P1 = 5;
  localparam int P2 = 6;
  localparam int PAD = 7;
  localparam syn_t SYN_D0 = 3'b011;
  localparam syn_t SYN_D1 = 3'b101;
  localparam syn_t SYN_D2 = 3'b110;
  localparam syn_t SYN_D3 = 3'b111;
  function automatic logic [0:3] correct(input logic [0:3] d, input syn_t s);
    return {d[0] ^ (s == SYN_D0), d[1] ^ (s == SYN_D1), d[2] ^ (s == SYN_D2), d[3] ^ (s == SYN_D3)};
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome of a 7-bit codeword
// Ports: code [0:6] = d0..d3,p0..p2; syn = {s2,s1,s0}
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [0:6] code,
  output syn_t       syn
);
  assign syn = {code[P2] ^ code[D1] ^ code[D2] ^ code[D3],
                code[P1] ^ code[D0] ^ code[D2] ^ code[D3],
                code[P0] ^ code[D0] ^ code[D1] ^ code[D3]};
endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage valid/ready Hamming(7,4) decoder with single-bit correction and pad check
module hamming_decoder
  import hamming_pkg::*;
#(parameter int CNT_W = 16)
(
  input  logic             clk,
  input  logic             reset,
`ifdef HAMMING_DEC_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] pad_cnt,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:7]       byte_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:3]       nibble_out,
  output logic             err_corr,
  output logic             err_pad
);
  logic       adv;
  logic       s1_valid;
  logic [0:3] s1_data;
  logic       s1_pad;
  syn_t       syn;
  syn_t       s1_syn;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  hamming_syndrome u_syn (
    .code(byte_in[0:6]),
    .syn (syn)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_pad     <= 1'b0;
      s1_syn     <= '0;
      out_valid  <= 1'b0;
      nibble_out <= '0;
      err_corr   <= 1'b0;
      err_pad    <= 1'b0;
    end else if (adv) begin
      s1_valid   <= in_valid;
      s1_data    <= byte_in[D0:D3];
      s1_pad     <= byte_in[PAD];
      s1_syn     <= syn;
      out_valid  <= s1_valid;
      nibble_out <= correct(s1_data, s1_syn);
      err_corr   <= s1_valid && (s1_syn != '0);
      err_pad    <= s1_valid && s1_pad;
    end
  end
`ifdef HAMMING_DEC_STATS_EN
  logic xfer;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      corr_cnt <= '0;
      pad_cnt  <= '0;
    end else if (xfer) begin
      if (err_corr && !(&corr_cnt)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (err_pad && !(&pad_cnt)) pad_cnt <= pad_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: scoreboard bench for hamming_decoder (directed vectors, optional stats checks)
module tb_hamming_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [0:7] byte_in = '0;
  logic       in_ready;
  logic       out_valid;
  logic [0:3] nibble_out;
  logic       err_corr;
  logic       err_pad;
`ifdef HAMMING_DEC_STATS_EN
  logic       stats_clr = 1'b0;
  logic [1:0] corr_cnt;
  logic [1:0] pad_cnt;
`endif
  hamming_decoder #(.CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef HAMMING_DEC_STATS_EN
    .stats_clr (stats_clr),
    .corr_cnt  (corr_cnt),
    .pad_cnt   (pad_cnt),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .byte_in   (byte_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nibble_out(nibble_out),
    .err_corr  (err_corr),
    .err_pad   (err_pad)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [0:3] nib;
    logic       corr;
    logic       pad;
    logic       lat;
    int         acc;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(logic [0:7] b, logic [0:3] nib, logic corr, logic pad, logic lat);
    bit acc = 0;
    exp_t e;
    in_valid = 1'b1;
    byte_in = b;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        e = '{nib, corr, pad, lat, cyc};
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want accept of %b", b);
    end
  endtask
  initial begin
    logic held;
    logic [0:3] h_nib;
    logic h_corr, h_pad;
    exp_t e;
`ifdef HAMMING_DEC_STATS_EN
    int m_corr, m_pad;
    m_corr = 0;
    m_pad = 0;
`endif
    held = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 0;
`ifdef HAMMING_DEC_STATS_EN
        m_corr = 0;
        m_pad = 0;
`endif
      end else begin
        check("in_ready_adv", in_ready, !out_valid || out_ready);
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_nibble", nibble_out, h_nib);
          check("hold_corr", err_corr, h_corr);
          check("hold_pad", err_pad, h_pad);
        end
        held = out_valid && !out_ready;
        h_nib = nibble_out;
        h_corr = err_corr;
        h_pad = err_pad;
`ifdef HAMMING_DEC_STATS_EN
        check("corr_cnt", corr_cnt, m_corr);
        check("pad_cnt", pad_cnt, m_pad);
`endif
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got nibble %b want none", nibble_out);
          end else begin
            e = sb.pop_front();
            check("nibble", nibble_out, e.nib);
            check("err_corr", err_corr, e.corr);
            check("err_pad", err_pad, e.pad);
            if (e.lat) check("latency", cyc, e.acc + 2);
`ifdef HAMMING_DEC_STATS_EN
            if (!stats_clr) begin
              if (e.corr && m_corr < 3) m_corr++;
              if (e.pad && m_pad < 3) m_pad++;
            end
`endif
          end
        end
`ifdef HAMMING_DEC_STATS_EN
        if (stats_clr) begin
          m_corr = 0;
          m_pad = 0;
        end
`endif
      end
    end
  end
  initial begin
    idle(2);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_nibble", nibble_out, 0);
    check("rst_err_corr", err_corr, 0);
    check("rst_err_pad", err_pad, 0);
`ifdef HAMMING_DEC_STATS_EN
    check("rst_corr_cnt", corr_cnt, 0);
    check("rst_pad_cnt", pad_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'b1011_0100, 4'b1011, 0, 0, 1);
    idle(3);
    send(8'b1001_0100, 4'b1011, 1, 0, 1);
    idle(3);
    send(8'b1011_1100, 4'b1011, 1, 0, 1);
    idle(3);
    send(8'b1011_0101, 4'b1011, 0, 1, 1);
    idle(3);
`ifdef HAMMING_DEC_STATS_EN
    @(negedge clk);
    check("dir_pad_cnt", pad_cnt, 1);
    check("dir_corr_cnt", corr_cnt, 2);
    @(posedge clk);
    #1;
`endif
    send(8'b0011_0100, 4'b1011, 1, 0, 1);
    send(8'b1111_0100, 4'b1011, 1, 0, 1);
    send(8'b1010_0100, 4'b1011, 1, 0, 1);
    send(8'b0000_0000, 4'b0000, 0, 0, 1);
    send(8'b1111_1110, 4'b1111, 0, 0, 1);
    send(8'b0000_0010, 4'b0000, 1, 0, 1);
    send(8'b0000_0101, 4'b0000, 1, 1, 1);
    send(8'b0010_1100, 4'b0110, 1, 0, 1);
    idle(4);
    fork
      begin
        send(8'b0110_1100, 4'b0110, 0, 0, 0);
        send(8'b1111_1110, 4'b1111, 0, 0, 0);
        send(8'b0000_0000, 4'b0000, 0, 0, 0);
        send(8'b1001_0100, 4'b1011, 1, 0, 0);
      end
      begin
        idle(2);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
    send(8'b1011_0100, 4'b1011, 0, 0, 0);
    send(8'b1111_1110, 4'b1111, 0, 0, 0);
    reset = 1'b1;
    sb.delete();
    idle(2);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err_corr", err_corr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (3) begin
      check("mid_rst_flushed", out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
`ifdef HAMMING_DEC_STATS_EN
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    repeat (5) send(8'b1001_0100, 4'b1011, 1, 0, 1);
    idle(4);
    @(negedge clk);
    check("sat_corr_cnt", corr_cnt, 3);
    @(posedge clk);
    #1;
    stats_clr = 1'b1;
    send(8'b1011_1100, 4'b1011, 1, 0, 1);
    idle(3);
    @(negedge clk);
    check("clr_corr_cnt", corr_cnt, 0);
    check("clr_pad_cnt", pad_cnt, 0);
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
`endif
    for (int t = 0; t < 20 && sb.size() != 0; t++) idle(1);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
